instr_fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of the control unit. It holds the PC, fetches 16-bit instruction words from instruction memory over a req/valid handshake, and presents one instruction at a time with its opcode field (instr[15:12]) to decode and control on a valid/ready handshake. It accepts PC redirects for JUMP and taken B from downstream, and parks permanently on halt.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/ifu_stat_ctr.sv | 17 +
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, opcode map and fetch-unit state encoding.
package cpu_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_OR   = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_LD   = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_ST   = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_MOV  = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_MOVI = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_JUMP = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_CMP  = 4'd12;
    localparam logic [OPCODE_W-1:0] OP_B    = 4'd13;
    localparam logic [OPCODE_W-1:0] OP_HLT  = 4'd15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        HALT  = 3'd4
    } ifu_state_t;

endpackage

// File: rtl/ifu_stat_ctr.sv
// Saturating 16-bit event counter used for fetch statistics (built only with IFU_STAT_EN).
module ifu_stat_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_count <= 16'd0;
        end else if (i_inc && (o_count != 16'hFFFF)) begin
            o_count <= o_count + 16'd1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/valid handshake, IR with valid/ready to decode.
// Optional IFU_STAT_EN adds saturating fetched/squashed counters.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// FETCH | latch request address, raise imem_req
// WAIT  | request outstanding; response loads IR or is discarded when squashed
// HOLD  | IR valid, waiting for downstream to accept it
// HALT  | parked until reset
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted
`ifdef IFU_STAT_EN
    ,
    output logic [15:0]        stat_fetched,
    output logic [15:0]        stat_squashed
`endif
);

    ifu_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_squash;

    assign opcode = instr[INSTR_W-1 -: OPCODE_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_squash    <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (halt || (r_state == HALT)) begin
            // Halt beats redirect and any response; a late response is simply never looked at.
            r_state     <= HALT;
            r_squash    <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (redirect_en) r_pc <= redirect_pc;
                    r_state <= FETCH;
                end
                FETCH: begin
                    imem_req  <= 1'b1;
                    imem_addr <= redirect_en ? redirect_pc : r_pc;
                    if (redirect_en) r_pc <= redirect_pc;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (imem_valid) begin
                        imem_req <= 1'b0;
                        r_squash <= 1'b0;
                        if (r_squash || redirect_en) begin
                            r_state <= FETCH;
                            if (redirect_en) r_pc <= redirect_pc;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            r_pc        <= r_pc + 1'b1;
                            r_state     <= HOLD;
                        end
                    end else if (redirect_en) begin
                        // Request must stay stable until memory answers; remember to drop it.
                        r_squash <= 1'b1;
                        r_pc     <= redirect_pc;
                    end
                end
                HOLD: begin
                    if (redirect_en || instr_ready) begin
                        instr_valid <= 1'b0;
                        r_state     <= FETCH;
                    end
                    if (redirect_en) r_pc <= redirect_pc;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef IFU_STAT_EN
    logic w_ir_load;
    logic w_discard;
    logic w_drop;

    assign w_ir_load = !halt && (r_state == WAIT) && imem_valid && !r_squash && !redirect_en;
    assign w_discard = !halt && (r_state == WAIT) && imem_valid && (r_squash || redirect_en);
    assign w_drop    = !halt && (r_state == HOLD) && redirect_en && !instr_ready;

    ifu_stat_ctr u_stat_fetched (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_ir_load),
        .o_count (stat_fetched)
    );

    ifu_stat_ctr u_stat_squashed (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_discard || w_drop),
        .o_count (stat_squashed)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table for the basic flow,
// then hand-written sequences for hold, squash, redirect collisions, PC wrap and halt.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_en;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: responds mem_lat negedges after seeing imem_req; force_valid injects a stray strobe.
    logic [15:0] mem [256];
    int          mem_lat     = 1;
    int          mem_cnt     = 0;
    logic        force_valid = 1'b0;

    always @(negedge clk) begin
        if (force_valid) begin
            imem_valid = 1'b1;
            imem_rdata = 16'hBAD0;
        end else if (imem_req === 1'b1) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt == mem_lat) begin
                imem_valid = 1'b1;
                imem_rdata = mem[imem_addr];
                mem_cnt    = 0;
            end else begin
                imem_valid = 1'b0;
                imem_rdata = 16'hDEAD;
            end
        end else begin
            mem_cnt    = 0;
            imem_valid = 1'b0;
            imem_rdata = 16'hBEEF;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        redir;
        logic [7:0]  rpc;
        logic        halt;
        logic        exp_req;
        logic [7:0]  exp_addr;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic [7:0]  exp_ipc;
        logic        exp_halted;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(16'hE000 | i);
        mem[8'h00] = 16'h0123;
        mem[8'h01] = 16'h5456;
        mem[8'h02] = 16'h2002;
        mem[8'h10] = 16'hD010;
        mem[8'h20] = 16'h8020;
        mem[8'h40] = 16'h9A40;
        mem[8'hFF] = 16'hF0FF;

        //          rst  rdy  red  rpc    hlt | req  addr   vld  instr     ipc    hlt
        vecs[0] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00, 1'b0,16'h0000, 8'h00, 1'b0};
        vecs[1] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00, 1'b0,16'h0000, 8'h00, 1'b0};
        vecs[2] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,8'h00, 1'b0,16'h0000, 8'h00, 1'b0};
        vecs[3] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00, 1'b1,16'h0123, 8'h00, 1'b0};
        vecs[4] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h00, 1'b0,16'h0123, 8'h00, 1'b0};
        vecs[5] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,8'h01, 1'b0,16'h0123, 8'h00, 1'b0};
        vecs[6] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h01, 1'b1,16'h5456, 8'h01, 1'b0};
        vecs[7] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h01, 1'b1,16'h5456, 8'h01, 1'b0};

        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 8'h00;
        halt        = 1'b0;

        for (int v = 0; v < 8; v++) begin
            rst_n       = vecs[v].rst_n;
            instr_ready = vecs[v].ready;
            redirect_en = vecs[v].redir;
            redirect_pc = vecs[v].rpc;
            halt        = vecs[v].halt;
            step();
            chk($sformatf("vec%0d_req", v),    imem_req,    vecs[v].exp_req);
            chk($sformatf("vec%0d_addr", v),   imem_addr,   vecs[v].exp_addr);
            chk($sformatf("vec%0d_valid", v),  instr_valid, vecs[v].exp_valid);
            chk($sformatf("vec%0d_instr", v),  instr,       vecs[v].exp_instr);
            chk($sformatf("vec%0d_opcode", v), opcode,      vecs[v].exp_instr[15:12]);
            chk($sformatf("vec%0d_ipc", v),    instr_pc,    vecs[v].exp_ipc);
            chk($sformatf("vec%0d_halted", v), halted,      vecs[v].exp_halted);
        end

        // Backpressure: IR and handshake frozen, no new request.
        instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_instr", instr, 16'h5456);
            chk("hold_req",   imem_req, 1'b0);
            chk("hold_valid", instr_valid, 1'b1);
        end
        instr_ready = 1'b1;
        step();
        chk("consume_valid", instr_valid, 1'b0);

        // Redirect during a 4-cycle memory wait.
        instr_ready = 1'b0;
        mem_lat     = 4;
        step();
        chk("fetch2_req",  imem_req, 1'b1);
        chk("fetch2_addr", imem_addr, 8'h02);
        redirect_en = 1'b1;
        redirect_pc = 8'h40;
        step();
        chk("squash_req",  imem_req, 1'b1);
        chk("squash_addr", imem_addr, 8'h02);
        redirect_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("squash_hold_req",  imem_req, 1'b1);
            chk("squash_hold_addr", imem_addr, 8'h02);
        end
        step();
        chk("squash_drop_req",   imem_req, 1'b0);
        chk("squash_drop_valid", instr_valid, 1'b0);
        chk("squash_drop_instr", instr, 16'h5456);
        step();
        chk("redir_req",  imem_req, 1'b1);
        chk("redir_addr", imem_addr, 8'h40);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lat4_wait_valid", instr_valid, 1'b0);
        end
        step();
        chk("lat4_valid", instr_valid, 1'b1);
        chk("lat4_instr", instr, 16'h9A40);
        chk("lat4_ipc",   instr_pc, 8'h40);

        // Redirect colliding with imem_valid, then with instr_ready.
        mem_lat     = 1;
        instr_ready = 1'b1;
        step();
        chk("c_consume_valid", instr_valid, 1'b0);
        instr_ready = 1'b0;
        step();
        chk("c_fetch_addr", imem_addr, 8'h41);
        redirect_en = 1'b1;
        redirect_pc = 8'h10;
        step();
        chk("c_drop_req",   imem_req, 1'b0);
        chk("c_drop_valid", instr_valid, 1'b0);
        chk("c_drop_instr", instr, 16'h9A40);
        redirect_en = 1'b0;
        step();
        chk("c_tgt_req",  imem_req, 1'b1);
        chk("c_tgt_addr", imem_addr, 8'h10);
        step();
        chk("c_tgt_valid", instr_valid, 1'b1);
        chk("c_tgt_instr", instr, 16'hD010);
        chk("c_tgt_ipc",   instr_pc, 8'h10);
        instr_ready = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 8'h20;
        step();
        chk("c2_valid", instr_valid, 1'b0);
        chk("c2_req",   imem_req, 1'b0);
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        step();
        chk("c2_addr", imem_addr, 8'h20);
        chk("c2_req2", imem_req, 1'b1);
        step();
        chk("c2_instr",  instr, 16'h8020);
        chk("c2_opcode", opcode, 4'h8);
        chk("c2_ipc",    instr_pc, 8'h20);

        // Redirect to 0xFF dropping the IR, stray strobe in HOLD, then wrap.
        redirect_en = 1'b1;
        redirect_pc = 8'hFF;
        step();
        chk("w_drop_valid", instr_valid, 1'b0);
        redirect_en = 1'b0;
        step();
        chk("w_addr_ff", imem_addr, 8'hFF);
        step();
        chk("w_instr", instr, 16'hF0FF);
        chk("w_ipc",   instr_pc, 8'hFF);
        force_valid = 1'b1;
        step();
        chk("stray_instr", instr, 16'hF0FF);
        chk("stray_valid", instr_valid, 1'b1);
        force_valid = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("w_consume", instr_valid, 1'b0);
        instr_ready = 1'b0;
        step();
        chk("wrap_req",  imem_req, 1'b1);
        chk("wrap_addr", imem_addr, 8'h00);

        // Halt with redirect and response in the same cycle; park until reset.
        halt        = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 8'h33;
        step();
        chk("halt_halted", halted, 1'b1);
        chk("halt_req",    imem_req, 1'b0);
        chk("halt_valid",  instr_valid, 1'b0);
        halt = 1'b0;
        for (int k = 0; k < 8; k++) begin
            instr_ready = k[0];
            redirect_en = k[1];
            force_valid = k[2];
            step();
            chk("parked_halted", halted, 1'b1);
            chk("parked_req",    imem_req, 1'b0);
            chk("parked_valid",  instr_valid, 1'b0);
        end
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        force_valid = 1'b0;
        rst_n       = 1'b0;
        step();
        chk("rst_halted", halted, 1'b0);
        chk("rst_req",    imem_req, 1'b0);
        chk("rst_addr",   imem_addr, 8'h00);
        chk("rst_valid",  instr_valid, 1'b0);
        chk("rst_instr",  instr, 16'h0000);
        chk("rst_ipc",    instr_pc, 8'h00);
        rst_n = 1'b1;
        step();
        chk("rst_idle_req", imem_req, 1'b0);
        step();
        chk("rst_fetch_req",  imem_req, 1'b1);
        chk("rst_fetch_addr", imem_addr, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
